// File: rtl/ahb_pkg.sv
// ahb_pkg: shared AHB-Lite transfer encodings and data-phase owner encoding
package ahb_pkg;
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_M0   = 2'd1,
    OWN_M1   = 2'd2
  } owner_t;
endpackage

// File: rtl/ahb_input_stage.sv
// ahb_input_stage: one-entry address-phase buffer and HREADY generation for one master port
module ahb_input_stage
  import ahb_pkg::*;
#(
  parameter int ADDRW = 32
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  input  logic             hsel,
  input  logic [ADDRW-1:0] haddr,
  input  logic [1:0]       htrans,
  input  logic             hwrite,
  input  logic [2:0]       hsize,
  input  logic             issue,
  input  logic             own,
  input  logic             slave_ready,
  output logic             hready,
  output logic             req,
  output logic [ADDRW-1:0] addr,
  output logic             write,
  output logic [2:0]       size
);
  logic             live;
  logic             pend;
  logic [ADDRW-1:0] addr_q;
  logic             write_q;
  logic [2:0]       size_q;
  // a buffered master is held off until its own data phase completes
  assign hready = own ? slave_ready : ~pend;
  assign live   = hsel & (htrans == HTRANS_NONSEQ || htrans == HTRANS_SEQ) & hready;
  assign req    = pend | live;
  assign addr   = pend ? addr_q : haddr;
  assign write  = pend ? write_q : hwrite;
  assign size   = pend ? size_q : hsize;
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) begin
      pend    <= 1'b0;
      addr_q  <= '0;
      write_q <= 1'b0;
      size_q  <= '0;
    end else if (live && !issue) begin
      pend    <= 1'b1;
      addr_q  <= haddr;
      write_q <= hwrite;
      size_q  <= hsize;
    end else if (issue)
      pend <= 1'b0;
endmodule

// File: rtl/ahb_mem_arbiter2.sv
// ahb_mem_arbiter2: round-robin sharing of one AHB-Lite memory slave between two masters
module ahb_mem_arbiter2
  import ahb_pkg::*;
#(
  parameter int ADDRW = 32
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  input  logic             M0_HSEL,
  input  logic [ADDRW-1:0] M0_HADDR,
  input  logic [1:0]       M0_HTRANS,
  input  logic             M0_HWRITE,
  input  logic [2:0]       M0_HSIZE,
  input  logic [31:0]      M0_HWDATA,
  output logic             M0_HREADY,
  output logic [31:0]      M0_HRDATA,
  input  logic             M1_HSEL,
  input  logic [ADDRW-1:0] M1_HADDR,
  input  logic [1:0]       M1_HTRANS,
  input  logic             M1_HWRITE,
  input  logic [2:0]       M1_HSIZE,
  input  logic [31:0]      M1_HWDATA,
  output logic             M1_HREADY,
  output logic [31:0]      M1_HRDATA,
  output logic             S_HSEL,
  output logic [ADDRW-1:0] S_HADDR,
  output logic [1:0]       S_HTRANS,
  output logic             S_HWRITE,
  output logic [2:0]       S_HSIZE,
  output logic [31:0]      S_HWDATA,
  output logic             S_HREADY,
  input  logic             S_HREADYOUT,
  input  logic [31:0]      S_HRDATA
);
  owner_t           owner;
  logic             last_grant;
  logic             req0, req1, gnt0, gnt1, issue;
  logic [ADDRW-1:0] addr0, addr1, addr_q;
  logic             write0, write1, write_q;
  logic [2:0]       size0, size1, size_q;
  ahb_input_stage #(.ADDRW(ADDRW)) u_in0 (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .hsel(M0_HSEL), .haddr(M0_HADDR), .htrans(M0_HTRANS), .hwrite(M0_HWRITE), .hsize(M0_HSIZE),
    .issue(gnt0), .own(owner == OWN_M0), .slave_ready(S_HREADYOUT),
    .hready(M0_HREADY), .req(req0), .addr(addr0), .write(write0), .size(size0)
  );
  ahb_input_stage #(.ADDRW(ADDRW)) u_in1 (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .hsel(M1_HSEL), .haddr(M1_HADDR), .htrans(M1_HTRANS), .hwrite(M1_HWRITE), .hsize(M1_HSIZE),
    .issue(gnt1), .own(owner == OWN_M1), .slave_ready(S_HREADYOUT),
    .hready(M1_HREADY), .req(req1), .addr(addr1), .write(write1), .size(size1)
  );
  // on a tie the master that did not win last time goes first
  assign gnt0  = S_HREADYOUT & req0 & (~req1 | last_grant);
  assign gnt1  = S_HREADYOUT & req1 & (~req0 | ~last_grant);
  assign issue = gnt0 | gnt1;
  assign S_HSEL    = issue;
  assign S_HTRANS  = issue ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign S_HADDR   = gnt0 ? addr0 : gnt1 ? addr1 : addr_q;
  assign S_HWRITE  = gnt0 ? write0 : gnt1 ? write1 : write_q;
  assign S_HSIZE   = gnt0 ? size0 : gnt1 ? size1 : size_q;
  assign S_HWDATA  = owner == OWN_M0 ? M0_HWDATA : owner == OWN_M1 ? M1_HWDATA : 32'h0;
  assign S_HREADY  = S_HREADYOUT;
  assign M0_HRDATA = S_HRDATA;
  assign M1_HRDATA = S_HRDATA;
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) begin
      owner      <= OWN_NONE;
      last_grant <= 1'b1;
      addr_q     <= '0;
      write_q    <= 1'b0;
      size_q     <= '0;
    end else if (S_HREADYOUT) begin
      owner <= gnt0 ? OWN_M0 : gnt1 ? OWN_M1 : OWN_NONE;
      if (issue) begin
        last_grant <= gnt1;
        addr_q     <= S_HADDR;
        write_q    <= S_HWRITE;
        size_q     <= S_HSIZE;
      end
    end
endmodule

// File: doc/ahb_mem_arbiter2.md
# ahb_mem_arbiter2

Two-master AHB-Lite arbiter that shares one AHB-Lite memory slave (the on-chip BRAM block) between two bus masters, e.g. the CPU and a DMA/debug master. Each master port has a one-entry address-phase buffer, so a master that loses arbitration is stalled with HREADY low and never loses a transfer. Grants are round-robin per transfer, and uncontended transfers pass through with zero added latency.

## Interface
Parameters:
- ADDRW, 32, address width carried through to the slave.

Ports (x = 0, 1):
- HCLK  in  1  clock.
- HRESETn  in  1  reset, asynchronous, active-low.
- Mx_HSEL  in  1  master x selects the memory region.
- Mx_HADDR  in  ADDRW  master x address.
- Mx_HTRANS  in  2  master x transfer type.
- Mx_HWRITE  in  1  master x write flag.
- Mx_HSIZE  in  3  master x transfer size.
- Mx_HWDATA  in  32  master x write data.
- Mx_HREADY  out  1  ready returned to master x.
- Mx_HRDATA  out  32  read data to master x; driven by S_HRDATA for both masters.
- S_HSEL  out  1  slave select.
- S_HADDR  out  ADDRW  slave address.
- S_HTRANS  out  2  slave transfer type.
- S_HWRITE  out  1  slave write flag.
- S_HSIZE  out  3  slave transfer size.
- S_HWDATA  out  32  slave write data.
- S_HREADY  out  1  equals S_HREADYOUT.
- S_HREADYOUT  in  1  slave ready.
- S_HRDATA  in  32  slave read data.

## Operation
- Live request: live_x = Mx_HSEL & Mx_HTRANS[1] & Mx_HREADY.
- Request: req_x = pend_x | live_x.
- Slot: any cycle with S_HREADYOUT = 1.
- Arbitration (slot cycles only):
  - One requester: it wins.
  - Both requesting: the master other than last_grant wins.
  - The winner is issued. last_grant takes the winner's index.
- Issue drive:
  - S_HSEL = 1, S_HTRANS = 2'b10 (NONSEQ). SEQ is always converted to NONSEQ; no burst locking.
  - S_HADDR, S_HWRITE and S_HSIZE come from the pending buffer if pend_x = 1, otherwise from the live inputs.
- No issue: S_HSEL = 0, S_HTRANS = 2'b00. The address/control outputs keep their last value.
- Capture: when live_x = 1 and master x is not issued this cycle, set pend_x and store its HADDR/HWRITE/HSIZE.
- pend_x clears in the slot where it is issued.
- dphase_owner (NONE/M0/M1), updated on each slot:
  - Becomes the issued master.
  - Becomes NONE if nothing was issued.
  - Holds its value when S_HREADYOUT = 0.
- S_HWDATA = Mx_HWDATA of dphase_owner; 0 when dphase_owner is NONE.
- Mx_HREADY (combinational):
  - S_HREADYOUT if dphase_owner = x.
  - Otherwise 0 if pend_x = 1.
  - Otherwise 1.
- A captured master sees HREADY low until its buffered transfer has been issued and that transfer's data phase completes.
- Boundary cases:
  - A master may own the data phase and present a new live request in the same slot. If it loses, the new request is captured while its current data phase completes normally.
  - A live request arriving while S_HREADYOUT = 0 from a non-owner is captured. An owner's request is not captured, because the owner already sees HREADY = 0 and holds its address.
  - A pending buffer is never overwritten, because Mx_HREADY = 0 while pend_x = 1.
  - HRESETn asserted mid-transfer discards pending buffers and the data phase with no completion. Sampled writes are lost.

## Timing
- Reset values:
  - pend_0 = pend_1 = 0.
  - dphase_owner = NONE.
  - last_grant = 1, so M0 wins the first tie.
  - Stored address/control = 0.
  - Hence Mx_HREADY = 1, S_HSEL = 0, S_HTRANS = 2'b00, S_HWDATA = 0.
- Uncontended latency is zero: the live address phase reaches the slave in the same cycle, through a combinational path.
- The contention loser is issued in the next slot. With a zero-wait slave, the loser's HREADY is low for exactly 1 extra cycle.
- Back-to-back contention alternates strictly: M0, M1, M0, …
- Registers update on the HCLK rising edge only.

## Structure
- ahb_pkg holds the HTRANS constants (IDLE/BUSY/NONSEQ/SEQ) and the owner encoding (NONE = 2'd0, M0 = 2'd1, M1 = 2'd2).
- Sub-module ahb_input_stage is instantiated once per master.
  - It contains the pend flag, the stored address/control, and the live/pending mux.
  - Inputs: issue_x and the owner/ready signals.
- The top level contains the arbiter, last_grant, dphase_owner and the muxes.

## Test plan
- Reset with HRESETn = 0 -> both Mx_HREADY = 1, S_HSEL = 0, S_HTRANS = 00, S_HWDATA = 0.
- M0 alone writes word 0xDEADBEEF to 0x10, then reads 0x10, with a zero-wait slave -> S_HADDR = 0x10 in the same cycle, no M0 stall, read returns 0xDEADBEEF.
- M0 and M1 issue NONSEQ in the same cycle after reset -> M0 issued first; M1 captured with M1_HREADY = 0 for one cycle; M1 issued next slot with its original address.
- Both masters stream 4 transfers each -> slave sees strict alternation M0, M1, M0, M1…; every write lands and every read returns the correct data to the correct master.
- Slave inserts 2 wait states on M0's data phase while M1 requests -> M1 is captured; M0_HREADY low for 2 cycles; M1 issued only when S_HREADYOUT returns 1.
- HRESETn pulsed while pend_1 = 1 -> pend cleared, no slave transfer issued afterwards, M1_HREADY = 1.
